// File: rtl/fir_pkg.sv
// Shared types and limits for the FIR control slice: sequencer state encoding,
// address/count widths and the run-length helper used at start-request time.
package fir_pkg;

  localparam int ADDR_W   = 13;
  localparam int CNT_W    = 15;
  localparam int P_W      = 14;
  localparam int MAX_RAZY = 8192;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CALC  = 3'd2,
    S_DRAIN = 3'd3,
    S_STORE = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6
  } fir_ctrl_state_t;

  // P + W - 1 in the full counter width, so an oversized request stays visible.
  function automatic logic [CNT_W-1:0] calc_razy(input logic [P_W-1:0]   p,
                                                 input logic [CNT_W-1:0] w);
    return CNT_W'(p) + w - CNT_W'(1);
  endfunction

endpackage

// File: rtl/fir_ctrl_fsm_if.sv
// Signal bundle between the FIR sequencer (master) and the counter / MAC /
// result memory it drives (slave).
interface fir_ctrl_fsm_if #(parameter int W_WSP = 8);
  import fir_pkg::*;

  // Counter handshake is pulse based: FSM_zapisz_probki and FSM_reset_licznik
  // fire together for one cycle, FSM_nowa_probka fires once per stored result,
  // and the counter's A_probki_FIR / licznik_full settle by the next edge.
  logic                 start;
  logic [P_W-1:0]       ile_probek;
  logic [W_WSP-1:0]     ile_wsp;
  logic [ADDR_W-1:0]    A_probki_FIR;
  logic                 licznik_full;
  logic [CNT_W-1:0]     ile_razy;
  logic                 FSM_zapisz_probki;
  logic                 FSM_reset_licznik;
  logic                 FSM_nowa_probka;
  logic [W_WSP-1:0]     A_wsp;
  logic [ADDR_W-1:0]    A_x;
  logic                 x_zero;
  logic                 mac_clr;
  logic                 mac_en;
  logic                 wynik_we;
  logic [ADDR_W-1:0]    A_wynik;
  logic                 busy;
  logic                 done;
  logic                 err;
  fir_ctrl_state_t      state_dbg;

  modport master (
    input  start, ile_probek, ile_wsp, A_probki_FIR, licznik_full,
    output ile_razy, FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka,
           A_wsp, A_x, x_zero, mac_clr, mac_en, wynik_we, A_wynik,
           busy, done, err, state_dbg
  );

  modport slave (
    output start, ile_probek, ile_wsp, A_probki_FIR, licznik_full,
    input  ile_razy, FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka,
           A_wsp, A_x, x_zero, mac_clr, mac_en, wynik_we, A_wynik,
           busy, done, err, state_dbg
  );

endinterface

// File: rtl/fir_addr_gen.sv
// Coefficient index k and sample address n-k for the MAC sweep, registered so
// the address outputs carry no combinational path from the counter input.
module fir_addr_gen
  import fir_pkg::*;
#(
  parameter int W_WSP = 8
) (
  input  logic              clk_b,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              issue,
  input  logic              first,
  input  logic              n_zero,
  input  logic [ADDR_W-1:0] n_in,
  input  logic [P_W-1:0]    p,
  output logic [W_WSP-1:0]  k,
  output logic [ADDR_W-1:0] a_x,
  output logic              x_zero
);

  logic [W_WSP-1:0] k_next;
  logic [P_W-1:0]   n_ext;
  logic [P_W-1:0]   k_ext;
  logic [P_W-1:0]   diff;

  // In LOAD the counter is being cleared on this very edge, so n is known to be 0.
  always_comb begin
    k_next = first ? '0 : k + W_WSP'(1);
    n_ext  = n_zero ? '0 : {1'b0, n_in};
    k_ext  = P_W'(k_next);
    diff   = n_ext - k_ext;
  end

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      k      <= '0;
      a_x    <= '0;
      x_zero <= 1'b0;
    end else if (issue) begin
      k      <= k_next;
      a_x    <= diff[ADDR_W-1:0];
      x_zero <= (k_ext > n_ext) || (diff >= p);
    end else if (clear) begin
      k      <= '0;
    end
  end

endmodule

// File: rtl/fir_ctrl_fsm.sv
// FIR sequencer: walks every output index n, sweeps all coefficients through
// the MAC, drains the pipeline, writes the result and steps the sample counter.
module fir_ctrl_fsm
  import fir_pkg::*;
#(
  parameter int PIPE_LAT = 3,
  parameter int W_WSP    = 8
) (
  input  logic           clk_b,
  input  logic           rst_n,
  fir_ctrl_fsm_if.master bus
);

  localparam logic [7:0] DRAIN_LAST = 8'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

  fir_ctrl_state_t    state;
  logic [P_W-1:0]     p_q;
  logic [W_WSP-1:0]   w_q;
  logic [7:0]         drain_cnt;
  logic [CNT_W-1:0]   razy_req;
  logic               req_ok;
  logic [CNT_W-1:0]   ile_razy_q;
  logic               zapisz_q, reset_lic_q, nowa_q, wynik_we_q;
  logic               mac_clr_q, mac_en_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0]  a_wynik_q;
  logic [W_WSP-1:0]   k;
  logic [ADDR_W-1:0]  a_x;
  logic               x_zero;
  logic               k_last;
  logic               ag_issue, ag_first, ag_n_zero, ag_clear;

  always_comb begin
    razy_req  = calc_razy(bus.ile_probek, CNT_W'(bus.ile_wsp));
    req_ok    = (bus.ile_probek != '0) && (bus.ile_wsp != '0) &&
                (razy_req <= CNT_W'(MAX_RAZY));
    k_last    = (k == w_q - W_WSP'(1));
    // Load the address generator whenever the next cycle is a CALC cycle.
    ag_issue  = (state == S_LOAD) ||
                (state == S_CALC && !k_last) ||
                (state == S_CHECK && !bus.licznik_full);
    ag_first  = (state != S_CALC);
    ag_n_zero = (state == S_LOAD);
    ag_clear  = (state == S_STORE);
  end

  fir_addr_gen #(.W_WSP(W_WSP)) u_addr_gen (
    .clk_b  (clk_b),
    .rst_n  (rst_n),
    .clear  (ag_clear),
    .issue  (ag_issue),
    .first  (ag_first),
    .n_zero (ag_n_zero),
    .n_in   (bus.A_probki_FIR),
    .p      (p_q),
    .k      (k),
    .a_x    (a_x),
    .x_zero (x_zero)
  );

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      p_q         <= '0;
      w_q         <= '0;
      drain_cnt   <= '0;
      ile_razy_q  <= '0;
      zapisz_q    <= 1'b0;
      reset_lic_q <= 1'b0;
      nowa_q      <= 1'b0;
      wynik_we_q  <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      a_wynik_q   <= '0;
    end else begin
      zapisz_q    <= 1'b0;
      reset_lic_q <= 1'b0;
      nowa_q      <= 1'b0;
      wynik_we_q  <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (!req_ok) begin
              err_q <= 1'b1;
            end else begin
              p_q         <= bus.ile_probek;
              w_q         <= bus.ile_wsp;
              ile_razy_q  <= razy_req;
              zapisz_q    <= 1'b1;
              reset_lic_q <= 1'b1;
              busy_q      <= 1'b1;
              state       <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          mac_en_q  <= 1'b1;
          mac_clr_q <= 1'b1;
          state     <= S_CALC;
        end
        S_CALC: begin
          if (!k_last) begin
            mac_en_q <= 1'b1;
          end else if (PIPE_LAT == 0) begin
            wynik_we_q <= 1'b1;
            nowa_q     <= 1'b1;
            a_wynik_q  <= bus.A_probki_FIR;
            state      <= S_STORE;
          end else begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            wynik_we_q <= 1'b1;
            nowa_q     <= 1'b1;
            a_wynik_q  <= bus.A_probki_FIR;
            state      <= S_STORE;
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end
        S_STORE: state <= S_CHECK;
        // licznik_full already reflects the increment issued from STORE.
        S_CHECK: begin
          if (bus.licznik_full) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            mac_en_q  <= 1'b1;
            mac_clr_q <= 1'b1;
            state     <= S_CALC;
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ile_razy          = ile_razy_q;
  assign bus.FSM_zapisz_probki = zapisz_q;
  assign bus.FSM_reset_licznik = reset_lic_q;
  assign bus.FSM_nowa_probka   = nowa_q;
  assign bus.A_wsp             = k;
  assign bus.A_x               = a_x;
  assign bus.x_zero            = x_zero;
  assign bus.mac_clr           = mac_clr_q;
  assign bus.mac_en            = mac_en_q;
  assign bus.wynik_we          = wynik_we_q;
  assign bus.A_wynik           = a_wynik_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.err               = err_q;
  assign bus.state_dbg         = state;

endmodule

// File: doc/fir_ctrl_fsm.md
# fir_ctrl_fsm

Sequencer that drives the FIR sample-address counter and the MAC datapath. On `start` it loads the run length `ile_probek + ile_wsp - 1` into the counter and walks every output index n. For each n it sweeps all coefficients k, issuing coefficient address k and sample address n-k with a zero-gate flag, drains the MAC pipeline, writes the result, and advances the counter. It is the initiator side of the counter handshake: it produces `FSM_zapisz_probki`, `FSM_reset_licznik` and `FSM_nowa_probka`, and it consumes `A_probki_FIR` and `licznik_full`.

## Interface
- PIPE_LAT, 3: cycles from the last `mac_en` to a valid accumulator output (memory read plus MAC).
- W_WSP, 8: width of `ile_wsp` and `A_wsp`.
- clk_b  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle run request; sampled only in IDLE
- ile_probek  in  14  number of input samples P, legal range 1..8192
- ile_wsp  in  W_WSP  number of coefficients W, legal range 1..2^W_WSP-1
- A_probki_FIR  in  13  output index n, from the counter
- licznik_full  in  1  counter-exhausted flag
- ile_razy  out  15  P+W-1, held stable from LOAD onwards
- FSM_zapisz_probki, FSM_reset_licznik  out  1  one-cycle pulses in LOAD
- FSM_nowa_probka  out  1  one-cycle pulse in STORE
- A_wsp  out  W_WSP  coefficient address k
- A_x  out  13  sample address n-k, modulo 2^13
- x_zero  out  1  high when k>n or n-k≥P; the MAC substitutes 0 for x
- mac_clr  out  1  clear accumulator; coincides with the first `mac_en` of each n
- mac_en  out  1  accumulate this cycle
- wynik_we  out  1  result write strobe
- A_wynik  out  13  result address, equal to n
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a run
- err  out  1  one-cycle pulse when a start request is illegal

## Operation
- States: IDLE, LOAD, CALC, DRAIN, STORE, CHECK, DONE.
- IDLE, on `start`:
  - If P==0, W==0 or P+W-1>8192: pulse `err` and remain in IDLE.
  - Otherwise: latch P and W, register `ile_razy`, go to LOAD.
- LOAD: assert `FSM_zapisz_probki` and `FSM_reset_licznik` together; k←0; go to CALC.
- CALC:
  - Outputs each cycle: `mac_en`=1, `A_wsp`=k, `A_x`=n-k, `x_zero` per the rule above.
  - `mac_clr`=1 only when k==0.
  - When k==W-1 go to DRAIN; otherwise k←k+1.
- DRAIN: hold for PIPE_LAT cycles. With PIPE_LAT=0, skip DRAIN and go straight to STORE.
- STORE: assert `wynik_we` with `A_wynik`=n and `FSM_nowa_probka` in the same cycle; k←0; go to CHECK.
- CHECK: sample `licznik_full`, which now reflects this cycle's increment. If 1, go to DONE; otherwise go to CALC.
- `licznik_full` is evaluated only in CHECK. A value left over from a previous run is cleared by the first increment of the new run and is never acted on.
- DONE: pulse `done`; go to IDLE.
- `start` outside IDLE is ignored.
- Width rules:
  - `ile_razy` = zero-extended P + zero-extended W - 1, computed in 15 bits.
  - `x_zero` compares on 14-bit extended operands: (k > n) OR (n - k ≥ P).
- Reset, including mid-run: state←IDLE, k←0, all outputs 0. The counter is reset by the same `rst_n`.

## Timing
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- `start` sampled at edge t means LOAD is the cycle after t, and the first CALC cycle follows it. `A_probki_FIR` is 0 by then.
- Each output index takes W + PIPE_LAT + 2 cycles (CALC, DRAIN, STORE, CHECK).
- A full run takes 1 (LOAD) + R·(W+PIPE_LAT+2) + 1 (DONE) cycles, where R=P+W-1.
- `A_probki_FIR` updates at the edge ending STORE, so the next CALC sees n+1.
- `busy` rises in the LOAD cycle and falls after DONE.

## Structure
- Package `fir_pkg`: state enum `fir_ctrl_state_t`, `ADDR_W`=13, `CNT_W`=15, `MAX_RAZY`=8192.
- Sub-module `fir_addr_gen`: k register, n-k subtraction and `x_zero` compare. The FSM stays in the top level.
- The bench instantiates the real counter alongside this block.

## Test plan
- P=4, W=3, PIPE_LAT=3, run with the real counter:
  - R=6, giving 6 `wynik_we` pulses with `A_wynik` 0..5.
  - For n=0, `x_zero` pattern over k is 0,1,1; for n=5 it is 1,1,0.
  - `done` arrives 50 cycles after LOAD starts.
- P=1, W=1: single output; `mac_clr`, `mac_en` and `wynik_we` each pulse once; `done` follows.
- `start` with P=0, then W=0, then P=8000 and W=200: `err` pulses each time, and `busy` and all counter strobes stay 0.
- Two back-to-back runs: the stale `licznik_full`=1 left by run 1 does not end run 2 early, and run 2 produces all R outputs.
- `start` pulsed mid-CALC: ignored, and the output sequence is unchanged.
- `rst_n` asserted mid-DRAIN: all outputs go to 0 asynchronously; after release the block sits in IDLE, and a new `start` runs cleanly from n=0.
